// File: rtl/matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_scanner : column-multiplexed 5x7 LED driver with a double-buffered |
// | frame; new frames swap in only on the column wrap. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module matrix_scanner #(
   parameter int COLS = 5,
   parameter int ROWS = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick_in,
   input  logic                 enable,
   input  logic                 load_valid,
   input  logic [COLS*ROWS-1:0] load_data,
   output logic                 load_ready,
   output logic [COLS-1:0]      col_n,
   output logic [ROWS-1:0]      row_out,
   output logic                 frame_done
);

   localparam int            IW         = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [IW-1:0] C_LAST_IDX = IW'(COLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   logic                 s1_q, s2_q, s3_q;
   logic                 w_step;
   logic                 w_advance, w_wrap, w_accept;

   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [COLS*ROWS-1:0] active_q, active_d;
   logic [COLS*ROWS-1:0] shadow_q, shadow_d;
   logic                 pending_q, pending_d;
   logic                 load_ready_q, load_ready_d;
   logic [COLS-1:0]      col_n_q, col_n_d;
   logic [ROWS-1:0]      row_out_q, row_out_d;
   logic                 frame_done_q, frame_done_d;

   // tick_in is asynchronous: two flops to synchronise, a third to find its rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= tick_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign w_step = s2_q & ~s3_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      w_advance = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (w_step && enable) begin
               state_d   = ST_BLANK;
               w_advance = 1'b1;
            end
         end
         ST_BLANK: begin
            state_d = enable ? ST_DRIVE : ST_IDLE;
         end
         ST_DRIVE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (w_step) begin
               state_d   = ST_BLANK;
               w_advance = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      w_wrap = w_advance && (idx_q == C_LAST_IDX);
      if (w_advance) begin
         idx_d = w_wrap ? '0 : idx_q + 1'b1;
      end

      // An accept needs pending low, so it can never coincide with a swap
      w_accept = load_valid && load_ready_q;
      if (w_accept) begin
         shadow_d  = load_data;
         pending_d = 1'b1;
      end else if (w_wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      load_ready_d = ~pending_d;
      frame_done_d = w_wrap;

      // Outputs are built from next-state values so they can be registered
      col_n_d   = '1;
      row_out_d = '0;
      if (state_d == ST_DRIVE) begin
         for (int c = 0; c < COLS; c++) begin
            if (idx_d == IW'(c)) begin
               col_n_d[c] = 1'b0;
               row_out_d  = active_d[c*ROWS +: ROWS];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= C_LAST_IDX;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         load_ready_q <= 1'b1;
         col_n_q      <= '1;
         row_out_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         load_ready_q <= load_ready_d;
         col_n_q      <= col_n_d;
         row_out_q    <= row_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign load_ready = load_ready_q;
   assign col_n      = col_n_q;
   assign row_out    = row_out_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_scanner : self-checking bench for matrix_scanner.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_matrix_scanner;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        tick_in    = 1'b0;
   logic        enable     = 1'b0;
   logic        load_valid = 1'b0;
   logic [34:0] load_data  = '0;
   logic        load_ready;
   logic [4:0]  col_n;
   logic [6:0]  row_out;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] col_n;
      logic [6:0] row;
      logic       fd;
   } exp_t;

   typedef struct {
      int         hi;
      int         lo;
      int         shift;
      logic [4:0] col_n;
      logic [6:0] row;
      logic       fd;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];

   matrix_scanner #(.COLS(5), .ROWS(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_in    (tick_in),
      .enable     (enable),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .col_n      (col_n),
      .row_out    (row_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [34:0] mk(input logic [6:0] c0, input logic [6:0] c1,
                                      input logic [6:0] c2, input logic [6:0] c3,
                                      input logic [6:0] c4);
      return {c4, c3, c2, c1, c0};
   endfunction

   function automatic logic [4:0] col_mask(input int c);
      logic [4:0] one;
      one = 5'b00001;
      return ~(one << c);
   endfunction

   function automatic logic [6:0] row_of(input logic [34:0] f, input int c);
      return f[c*7 +: 7];
   endfunction

   task automatic push(input int c, input logic [6:0] row, input logic fd);
      exp_t e;
      e.col_n = col_mask(c);
      e.row   = row;
      e.fd    = fd;
      sb.push_back(e);
   endtask

   // Called and returns at posedge+1; tick raised `shift` ns later, held hi edges, low lo edges
   task automatic tick(input int hi, input int lo, input int shift);
      #(shift);
      tick_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      tick_in = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input logic [34:0] d, input logic expect_ready);
      chk("ready_before_load", {31'd0, load_ready}, {31'd0, expect_ready});
      load_data  = d;
      load_valid = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      chk("ready_after_load", {31'd0, load_ready}, 32'd0);
   endtask

   // Scoreboard monitor: every new column drive pops one expected record
   logic [4:0] prev_col = 5'h1F;
   logic       fd_seen  = 1'b0;
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (frame_done) fd_seen = 1'b1;
      if (col_n != 5'h1F && prev_col == 5'h1F) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: col_n=%b row_out=%h but no column expected (t=%0t)",
                     col_n, row_out, $time);
         end else begin
            e = sb.pop_front();
            chk("sb_column", {19'd0, col_n, row_out, fd_seen}, {19'd0, e.col_n, e.row, e.fd});
         end
         fd_seen = 1'b0;
      end
      prev_col = col_n;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [34:0] f1, fa, fb, fc;
      f1 = mk(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
      fa = mk(7'h40, 7'h20, 7'h10, 7'h08, 7'h04);
      fb = mk(7'h2A, 7'h15, 7'h33, 7'h4C, 7'h7F);
      fc = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      tbl[0] = '{2, 3, 0, 5'b11101, 7'h02, 1'b0};
      tbl[1] = '{2, 2, 3, 5'b11011, 7'h04, 1'b0};
      tbl[2] = '{3, 2, 7, 5'b10111, 7'h08, 1'b0};
      tbl[3] = '{2, 3, 4, 5'b01111, 7'h10, 1'b0};
      tbl[4] = '{4, 4, 2, 5'b11110, 7'h01, 1'b1};
      tbl[5] = '{2, 3, 6, 5'b11101, 7'h02, 1'b0};
      tbl[6] = '{2, 2, 1, 5'b11011, 7'h04, 1'b0};
      tbl[7] = '{5, 2, 6, 5'b10111, 7'h08, 1'b0};
      tbl[8] = '{2, 3, 0, 5'b01111, 7'h10, 1'b0};
      tbl[9] = '{3, 3, 5, 5'b11110, 7'h01, 1'b1};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_col_n", {27'd0, col_n}, 32'h1F);
      chk("rst_row_out", {25'd0, row_out}, 32'h0);
      chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First frame, cycle-exact after one tick
      load_frame(f1, 1'b1);
      enable = 1'b1;
      push(0, 7'h01, 1'b1);
      tick_in = 1'b1;
      @(posedge clk); #1;
      chk("ff_k_col_n", {27'd0, col_n}, 32'h1F);
      @(posedge clk); #1;
      chk("ff_k1_col_n", {27'd0, col_n}, 32'h1F);
      chk("ff_k1_fd", {31'd0, frame_done}, 32'd0);
      chk("ff_k1_ready", {31'd0, load_ready}, 32'd0);
      tick_in = 1'b0;
      @(posedge clk); #1;
      chk("ff_k2_blank", {27'd0, col_n}, 32'h1F);
      chk("ff_k2_fd", {31'd0, frame_done}, 32'd1);
      chk("ff_k2_ready", {31'd0, load_ready}, 32'd1);
      @(posedge clk); #1;
      chk("ff_k3_col_n", {27'd0, col_n}, 32'h1E);
      chk("ff_k3_row", {25'd0, row_out}, 32'h01);
      chk("ff_k3_fd", {31'd0, frame_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Scan order with varied tick phases and offsets
      for (int i = 0; i < 10; i++) begin
         exp_t e;
         e.col_n = tbl[i].col_n;
         e.row   = tbl[i].row;
         e.fd    = tbl[i].fd;
         sb.push_back(e);
         tick(tbl[i].hi, tbl[i].lo, tbl[i].shift);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("scan_sb_drained", sb.size(), 32'd0);

      // Backpressure: A accepted, B refused until the swap frees the shadow
      load_frame(fa, 1'b1);
      repeat (3) load_frame(fb, 1'b0);
      for (int c = 1; c < 5; c++) begin
         push(c, row_of(f1, c), 1'b0);
         tick(2, 3, 0);
      end
      push(0, row_of(fa, 0), 1'b1);
      tick(2, 3, 0);
      chk("bp_ready_after_wrap", {31'd0, load_ready}, 32'd1);
      load_frame(fb, 1'b1);
      for (int c = 1; c < 5; c++) begin
         push(c, row_of(fa, c), 1'b0);
         tick(2, 3, 0);
      end
      push(0, row_of(fb, 0), 1'b1);
      tick(2, 3, 0);
      chk("bp_ready_after_wrap2", {31'd0, load_ready}, 32'd1);

      // Enable drop while column 2 is driven
      for (int c = 1; c < 3; c++) begin
         push(c, row_of(fb, c), 1'b0);
         tick(2, 3, 0);
      end
      chk("en_col2_driven", {27'd0, col_n}, 32'h1B);
      enable = 1'b0;
      @(posedge clk); #1;
      chk("en_blank_col_n", {27'd0, col_n}, 32'h1F);
      chk("en_blank_row", {25'd0, row_out}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick(2, 3, 0);
         chk("en_tick_ignored", {27'd0, col_n}, 32'h1F);
      end
      enable = 1'b1;
      push(3, row_of(fb, 3), 1'b0);
      tick(2, 3, 0);
      chk("en_resume_col3", {27'd0, col_n}, 32'h17);

      // Asynchronous reset mid-drive with a frame pending
      load_frame(fc, 1'b1);
      chk("pre_reset_col", {27'd0, col_n}, 32'h17);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_col_n", {27'd0, col_n}, 32'h1F);
      chk("arst_row_out", {25'd0, row_out}, 32'h0);
      chk("arst_load_ready", {31'd0, load_ready}, 32'd1);
      chk("arst_frame_done", {31'd0, frame_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push(0, 7'h00, 1'b1);
      tick(2, 3, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("final_sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
